// File: rtl/l2_cache_responder.sv
// L2 responder: buffers line read/write requests, services them against a
// direct-mapped write-back tag store with fixed latencies, returns completions.
module l2_cache_responder #(
   parameter int INDEX_BITS = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int HIT_LAT    = 2,
   parameter int MISS_LAT   = 8,
   parameter int WB_LAT     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  req_cmd,
   input  logic [25:0] req_add,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [1:0]  resp_cmd,
   output logic [25:0] resp_add,
   output logic        resp_hit,
   output logic [31:0] reads,
   output logic [31:0] writes,
   output logic [31:0] hits,
   output logic [31:0] misses,
   output logic [31:0] evictions
);

   localparam int TAGW = 26 - INDEX_BITS;
   localparam int SETS = 1 << INDEX_BITS;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int OW   = PW + 1;
   localparam int CW   = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      WAIT,
      RESP
   } state_e;

   state_e state_q, state_d;

   logic [27:0]     fifo_q [FIFO_DEPTH];
   logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic            push, pop, cmd_ok;

   logic [1:0]      cur_cmd_q;
   logic [25:0]     cur_add_q;
   logic            cur_hit_q;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [TAGW-1:0] tag_q [SETS];
   logic [SETS-1:0] valid_q, dirty_q;

   logic [INDEX_BITS-1:0] idx;
   logic [TAGW-1:0]       tag;
   logic                  hit, wb, lk;

   logic [31:0] reads_q, writes_q, hits_q, misses_q, evict_q;

   // ---------------- request FIFO ----------------
   assign cmd_ok    = (req_cmd == 2'b01) || (req_cmd == 2'b10);
   assign req_ready = (occ_q != OW'(FIFO_DEPTH));
   assign push      = req_valid && req_ready && cmd_ok;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      occ_d = occ_q;
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      if (push && !pop)      occ_d = occ_q + OW'(1);
      else if (!push && pop) occ_d = occ_q - OW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         occ_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         occ_q <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wp_q] <= {req_cmd, req_add};
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (occ_q != '0) state_d = LOOKUP;
         LOOKUP:  state_d = WAIT;
         WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop        = 1'b0;
      resp_valid = 1'b0;
      resp_cmd   = '0;
      resp_add   = '0;
      resp_hit   = 1'b0;
      unique case (state_q)
         IDLE: pop = (occ_q != '0);
         RESP: begin
            resp_valid = 1'b1;
            resp_cmd   = cur_cmd_q;
            resp_add   = cur_add_q;
            resp_hit   = cur_hit_q;
         end
         default: ;
      endcase
   end

   // ---------------- lookup datapath ----------------
   assign lk  = (state_q == LOOKUP);
   assign idx = cur_add_q[INDEX_BITS-1:0];
   assign tag = cur_add_q[25:INDEX_BITS];
   assign hit = valid_q[idx] && (tag_q[idx] == tag);
   assign wb  = !hit && valid_q[idx] && dirty_q[idx];

   always_comb begin
      cnt_d = cnt_q;
      if (lk) begin
         if (hit)     cnt_d = CW'(HIT_LAT);
         else if (wb) cnt_d = CW'(MISS_LAT + WB_LAT);
         else         cnt_d = CW'(MISS_LAT);
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_cmd_q <= '0;
         cur_add_q <= '0;
         cur_hit_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (pop) {cur_cmd_q, cur_add_q} <= fifo_q[rp_q];
         if (lk)  cur_hit_q <= hit;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lk && !hit) tag_q[idx] <= tag;
   end

   // Allocate on every miss; writes leave the line dirty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (lk) begin
         if (!hit) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= (cur_cmd_q == 2'b10);
         end else if (cur_cmd_q == 2'b10) begin
            dirty_q[idx] <= 1'b1;
         end
      end
   end

   // ---------------- statistics ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reads_q  <= '0;
         writes_q <= '0;
         hits_q   <= '0;
         misses_q <= '0;
         evict_q  <= '0;
      end else if (lk) begin
         if (cur_cmd_q == 2'b01) reads_q  <= reads_q + 32'd1;
         else                    writes_q <= writes_q + 32'd1;
         if (hit) hits_q   <= hits_q + 32'd1;
         else     misses_q <= misses_q + 32'd1;
         if (wb)  evict_q  <= evict_q + 32'd1;
      end
   end

   assign reads     = reads_q;
   assign writes    = writes_q;
   assign hits      = hits_q;
   assign misses    = misses_q;
   assign evictions = evict_q;

endmodule

// File: tb/tb_l2_cache_responder.sv
// Bench for l2_cache_responder: directed latency/backpressure/reset cases plus
// randomized traffic scored against a simple cache-and-queue model.
module tb_l2_cache_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_cmd;
   logic [25:0] req_add;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_cmd;
   logic [25:0] resp_add;
   logic        resp_hit;
   logic [31:0] reads, writes, hits, misses, evictions;

   l2_cache_responder dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_cmd    (req_cmd),
      .req_add    (req_add),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_cmd   (resp_cmd),
      .resp_add   (resp_add),
      .resp_hit   (resp_hit),
      .reads      (reads),
      .writes     (writes),
      .hits       (hits),
      .misses     (misses),
      .evictions  (evictions)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string t, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", t, got, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [1:0]  cmd;
      logic [25:0] add;
   } req_t;

   req_t        q[$];
   bit          mv [1024];
   bit          md [1024];
   logic [15:0] mt [1024];
   int unsigned m_rd, m_wr, m_hit, m_mis, m_ev;

   function automatic void m_clear();
      q.delete();
      for (int i = 0; i < 1024; i++) begin
         mv[i] = 0;
         md[i] = 0;
      end
      m_rd = 0; m_wr = 0; m_hit = 0; m_mis = 0; m_ev = 0;
   endfunction

   function automatic bit m_serve(req_t r);
      int          i;
      logic [15:0] tg;
      bit          h;
      i  = int'(r.add[9:0]);
      tg = r.add[25:10];
      h  = mv[i] && (mt[i] == tg);
      if (r.cmd == 2'b01) m_rd++;
      else                m_wr++;
      if (h) begin
         m_hit++;
         if (r.cmd == 2'b10) md[i] = 1;
      end else begin
         m_mis++;
         if (mv[i] && md[i]) m_ev++;
         mv[i] = 1;
         mt[i] = tg;
         md[i] = (r.cmd == 2'b10);
      end
      return h;
   endfunction

   // Sampled mid-cycle: what is seen here happens on the next rising edge.
   always @(negedge clk) begin
      req_t r;
      bit   h;
      if (rst) m_clear();
      else begin
         if (req_valid && req_ready && (req_cmd == 2'b01 || req_cmd == 2'b10))
            q.push_back('{req_cmd, req_add});
         if (resp_valid && resp_ready) begin
            chk("resp_pending", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
               r = q.pop_front();
               h = m_serve(r);
               chk("resp_cmd", 64'(resp_cmd), 64'(r.cmd));
               chk("resp_add", 64'(resp_add), 64'(r.add));
               chk("resp_hit", 64'(resp_hit), 64'(h));
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic send(logic [1:0] c, logic [25:0] a);
      int n = 0;
      req_valid = 1'b1;
      req_cmd   = c;
      req_add   = a;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 200) begin
            chk("send_ready", 64'(req_ready), 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!resp_valid && n < 300);
      if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 1);
   endtask

   task automatic lat_req(string t, logic [1:0] c, logic [25:0] a, int exp);
      int n;
      send(c, a);
      wait_resp(n);
      chk(t, 64'(n), 64'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || resp_valid) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 64'(q.size()), 0);
   endtask

   task automatic chk_stats();
      chk("reads",     64'(reads),     64'(m_rd));
      chk("writes",    64'(writes),    64'(m_wr));
      chk("hits",      64'(hits),      64'(m_hit));
      chk("misses",    64'(misses),    64'(m_mis));
      chk("evictions", 64'(evictions), 64'(m_ev));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w0;
      logic [25:0] a;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_cmd    = 2'b00;
      req_add    = '0;
      resp_ready = 1'b1;
      m_clear();
      do_reset();

      // reset state
      chk("rst_ready", 64'(req_ready), 1);
      chk("rst_rvalid", 64'(resp_valid), 0);
      chk_stats();

      // miss then hit on the same line
      lat_req("lat_miss", 2'b01, 26'h0000040, 10);
      lat_req("lat_hit",  2'b01, 26'h0000040, 4);
      chk("hits1", 64'(hits), 1);
      chk_stats();

      // dirty victim writeback, then clean victim
      lat_req("lat_wmiss", 2'b10, 26'h0000400, 10);
      lat_req("lat_wb",    2'b01, 26'h0001400, 14);
      chk("evict1", 64'(evictions), 1);
      lat_req("lat_clean", 2'b01, 26'h0000400, 10);
      chk("evict1b", 64'(evictions), 1);
      chk_stats();

      // backpressure: 5 writes with completions stalled
      w0 = int'(writes);
      resp_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(2'b10, 26'h0002000 + 26'(i * 3));
      chk("full_ready", 64'(req_ready), 0);
      req_valid = 1'b1;
      req_cmd   = 2'b10;
      req_add   = 26'h0003333;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_hold", 64'(req_ready), 0);
      end
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      drain();
      chk("writes5", 64'(int'(writes) - w0), 5);
      chk_stats();

      // illegal commands are ignored
      do_reset();
      for (int i = 0; i < 10; i++) begin
         req_valid = 1'b1;
         req_cmd   = (i < 5) ? 2'b00 : 2'b11;
         req_add   = 26'(i);
         @(negedge clk);
         chk("ign_rvalid", 64'(resp_valid), 0);
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         chk("ign_rvalid2", 64'(resp_valid), 0);
      end
      chk_stats();

      // reset while servicing with two entries queued
      lat_req("lat_pre", 2'b01, 26'h0000040, 10);
      send(2'b10, 26'h0000080);
      send(2'b10, 26'h00000c0);
      send(2'b10, 26'h0000100);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rvalid", 64'(resp_valid), 0);
      chk("mid_ready", 64'(req_ready), 1);
      chk("mid_reads", 64'(reads), 0);
      chk("mid_misses", 64'(misses), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         chk("post_rvalid", 64'(resp_valid), 0);
      end
      send(2'b01, 26'h0000040);
      begin
         int n;
         wait_resp(n);
         chk("lat_post", 64'(n), 10);
         chk("post_miss", 64'(resp_hit), 0);
      end
      @(posedge clk);
      #1;
      chk_stats();

      // nine back-to-back requests wrap the FIFO pointers
      resp_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) resp_ready = 1'b1;
         send(2'b10, 26'h0005000 + 26'(i * 26'h41));
      end
      drain();
      chk_stats();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         a = {14'($urandom_range(0, 3)), 2'b00, 10'($urandom_range(0, 3))};
         req_valid  = ($urandom_range(0, 1) == 1);
         req_cmd    = 2'($urandom_range(0, 3));
         req_add    = a;
         resp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      drain();
      repeat (2) @(posedge clk);
      #1;
      chk_stats();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/l2_cache_responder.md
Name: l2_cache_responder

Overview:
Next-level (L2) responder for the data cache's outbound request interface. Accepts line-address read (01) and write (10) commands and buffers them in a small FIFO. Services each command against a direct-mapped, write-back tag store with hit/miss/writeback latencies, then returns a completion. Keeps read/write/hit/miss/eviction statistics for the statistics module.

Parameters:
INDEX_BITS, 10, set index width; sets = 2**INDEX_BITS; tag width = 26-INDEX_BITS
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
HIT_LAT, 2, WAIT cycles on hit (>=1)
MISS_LAT, 8, WAIT cycles on miss (>=1)
WB_LAT, 4, extra WAIT cycles when a miss evicts a valid dirty line

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request strobe from data cache
req_cmd  in  2  01=read, 10=write; 00/11 ignored
req_add  in  26  line address (byte address [31:6])
req_ready  out  1  FIFO not full
resp_valid  out  1  completion valid
resp_ready  in  1  completion accepted
resp_cmd  out  2  command being completed
resp_add  out  26  address being completed
resp_hit  out  1  1 = completed as L2 hit
reads, writes, hits, misses, evictions  out  32 each  statistics counters

Behaviour:
- Reset (async assert, all state): every output 0 (req_ready=1 after reset), FIFO empty, FSM IDLE, all valid/dirty bits 0. Any in-flight request is dropped and no response is issued. Tag RAM contents are don't-care.
- Address split: index = req_add[INDEX_BITS-1:0], tag = req_add[25:INDEX_BITS].
- Accept: a request is accepted on an edge with req_valid & req_ready & (req_cmd==01 | req_cmd==10). cmd 00/11 is never enqueued or counted.
- Backpressure: req_ready = !full, from registered occupancy. A pop in the same cycle does not free the slot for the concurrent push.
- Simultaneous push and pop when not full: occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- IDLE: if FIFO is non-empty, pop the head into the working register and go to LOOKUP.
- LOOKUP (1 cycle): hit = valid[idx] & (tag_ram[idx]==tag).
  - Hit: load WAIT count HIT_LAT.
  - Miss: load MISS_LAT, plus WB_LAT if valid[idx] & dirty[idx]. On that writeback, evictions += 1.
  - Allocate on miss: tag_ram[idx]=tag, valid[idx]=1, dirty[idx] = (cmd==10).
  - Write hit: dirty[idx]=1. Read hit: dirty unchanged.
  - Statistics on this edge: reads or writes +1, and hits or misses +1.
  - Tag update is visible to the next LOOKUP, so back-to-back same-line requests hit.
  - Next state: WAIT.
- WAIT: counter decrements each edge. The edge where the count reaches 1 goes to RESP.
- RESP: resp_valid=1 with resp_cmd, resp_add and resp_hit held stable until the edge with resp_ready=1, then go to IDLE. resp_valid drops the following cycle.
- Latency: with an idle FSM, empty FIFO and resp_ready held 1, resp_valid rises LAT+2 cycles after the accepting edge (accept -> IDLE pop -> LOOKUP -> LAT WAIT cycles). Back-to-back responses are separated by at least one IDLE cycle.
- Statistics counters wrap at 2**32 with no saturation.
- FIFO entries keep their order. Requests accepted while the FSM is busy are serviced strictly FIFO.

Test Plan:
- Reset then read 0x0000040 (resp_ready=1) -> resp_valid 10 cycles after accept (MISS_LAT+2), resp_hit=0, reads=1, misses=1; repeat same address -> resp after 4 cycles, resp_hit=1, hits=1.
- Write 0x0000400, then read 0x0001400 (same index 0, different tag), then read 0x0000400 -> second request takes MISS_LAT+WB_LAT=12 WAIT cycles, evictions=1; third misses with no writeback (victim clean) and evictions stays 1.
- Hold resp_ready=0 and push 5 writes to distinct addresses -> 1 popped, 4 buffered, req_ready=0 after the 5th accept; a 6th req_valid is not accepted. Release resp_ready -> all 5 complete in order; writes=5.
- req_cmd=00 and 11 with req_valid=1 -> no enqueue, no response, all counters stay 0.
- Assert rst during WAIT with 2 entries queued -> outputs 0 immediately, no resp_valid after release; the previously allocated line now misses.
- Push and pop in the same cycle at occupancy 2 -> occupancy stays 2; pointer wrap after 9 sequential requests keeps order (check resp_add sequence).
